// File: rtl/cavlc_bit_packer_pkg.sv
// Shared constants, state encoding and code-beat type for the CAVLC bit packer
// and the code-table blocks feeding it.
package cavlc_bit_packer_pkg;

    localparam int CODE_W = 16;
    localparam int LEN_W  = 5;
    localparam int WORD_W = 32;
    localparam int ACC_W  = 64;
    localparam int CNT_W  = 6;

    typedef enum logic [1:0] {
        PK_RUN   = 2'd0,
        PK_FLUSH = 2'd1,
        PK_DONE  = 2'd2
    } pk_state_e;

    typedef struct packed {
        logic [CODE_W-1:0] bits;
        logic [LEN_W-1:0]  len;
    } vlc_code_t;

    // Lengths above the code width are treated as a full-width code.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len > 5'd16) ? 5'd16 : len;
    endfunction

    // Drop bits at/above len, then move the code to the top of the field.
    function automatic logic [CODE_W-1:0] left_align_code(input logic [CODE_W-1:0] bits,
                                                          input logic [LEN_W-1:0]  len);
        logic [CODE_W:0]   mask_w;
        logic [CODE_W-1:0] masked;
        mask_w = (17'd1 << len) - 17'd1;
        masked = bits & mask_w[CODE_W-1:0];
        return masked << (5'd16 - len);
    endfunction

endpackage

// File: rtl/cavlc_bit_packer_if.sv
// Code-beat input and packed-word output handshakes of the CAVLC bit packer.
// Signal names keep the packer-relative _i/_o suffixes.
interface cavlc_bit_packer_if;
    import cavlc_bit_packer_pkg::*;

    logic              code_valid_i;
    logic              code_ready_o;
    logic [CODE_W-1:0] code_bits_i;
    logic [LEN_W-1:0]  code_len_i;
    logic              flush_i;
    logic              word_valid_o;
    logic              word_ready_i;
    logic [WORD_W-1:0] word_data_o;
    logic              word_last_o;
    logic [2:0]        word_bytes_o;
    logic              flush_done_o;

    modport slave (
        input  code_valid_i, code_bits_i, code_len_i, flush_i, word_ready_i,
        output code_ready_o, word_valid_o, word_data_o, word_last_o, word_bytes_o,
               flush_done_o
    );

    modport master (
        output code_valid_i, code_bits_i, code_len_i, flush_i, word_ready_i,
        input  code_ready_o, word_valid_o, word_data_o, word_last_o, word_bytes_o,
               flush_done_o
    );

endinterface

// File: rtl/cavlc_bit_packer.sv
// Packs right-aligned VLC codes (0..16 bits) MSB-first into 32-bit words; flush closes
// the stream with a byte-counted final word. CAVLC_RBSP_TRAILING_EN adds the RBSP stop bit.
module cavlc_bit_packer
    import cavlc_bit_packer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    cavlc_bit_packer_if.slave  bus
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

`ifdef CAVLC_RBSP_TRAILING_EN
    localparam logic RBSP_EN = 1'b1;
`else
    localparam logic RBSP_EN = 1'b0;
`endif

    logic [1:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stop_pend_q, stop_pend_d;

    logic             full_s, final_s, wvalid_s, cready_s, accept_s, pop_s;
    logic [ACC_W-1:0] acc_pop_s;
    logic [CNT_W-1:0] cnt_pop_s;
    logic [CNT_W-1:0] bytes_sum_s;
    logic [LEN_W-1:0] len_eff_s;
    vlc_code_t        code_s;

    // Output view decoded from registered state only.
    always_comb begin
        full_s      = (cnt_q >= 6'd32);
        final_s     = (state_q == ST_FLUSH) && !stop_pend_q && !full_s && (cnt_q != 6'd0);
        wvalid_s    = (((state_q == ST_RUN) || (state_q == ST_FLUSH)) && full_s) || final_s;
        cready_s    = (state_q == ST_RUN) && (cnt_q <= 6'd47);
        bytes_sum_s = cnt_q + 6'd7;
        bus.code_ready_o = cready_s;
        bus.word_valid_o = wvalid_s;
        bus.word_data_o  = acc_q[ACC_W-1:ACC_W-WORD_W];
        bus.word_last_o  = final_s;
        bus.flush_done_o = (state_q == ST_DONE);
        if (final_s) begin
            bus.word_bytes_o = bytes_sum_s[5:3];
        end else if (wvalid_s) begin
            bus.word_bytes_o = 3'd4;
        end else begin
            bus.word_bytes_o = 3'd0;
        end
    end

    // Pop happens first; any new bits land right below what survives the pop.
    always_comb begin
        accept_s  = bus.code_valid_i && cready_s;
        pop_s     = wvalid_s && bus.word_ready_i;
        len_eff_s = clamp_len(bus.code_len_i);
        code_s    = {left_align_code(bus.code_bits_i, len_eff_s), len_eff_s};
        acc_pop_s = pop_s ? {acc_q[ACC_W-WORD_W-1:0], 32'h0000_0000} : acc_q;
        if (pop_s) begin
            cnt_pop_s = full_s ? (cnt_q - 6'd32) : 6'd0;
        end else begin
            cnt_pop_s = cnt_q;
        end

        state_d     = state_q;
        acc_d       = acc_pop_s;
        cnt_d       = cnt_pop_s;
        stop_pend_d = stop_pend_q;

        case (state_q)
            ST_RUN: begin
                if (accept_s) begin
                    acc_d = acc_pop_s | ({code_s.bits, 48'h0} >> cnt_pop_s);
                    cnt_d = cnt_pop_s + {1'b0, code_s.len};
                end else begin
                    acc_d = acc_pop_s;
                    cnt_d = cnt_pop_s;
                end
                if (bus.flush_i) begin
                    state_d     = ST_FLUSH;
                    stop_pend_d = RBSP_EN;
                end else begin
                    state_d     = ST_RUN;
                    stop_pend_d = 1'b0;
                end
            end
            ST_FLUSH: begin
                // Stop bit waits until it fits without overflowing the accumulator.
                if (stop_pend_q && (cnt_pop_s <= 6'd55)) begin
                    acc_d       = acc_pop_s | (64'h8000_0000_0000_0000 >> cnt_pop_s);
                    cnt_d       = (cnt_pop_s + 6'd8) & 6'b111000;
                    stop_pend_d = 1'b0;
                end else if (!stop_pend_q && !full_s && ((cnt_q == 6'd0) || pop_s)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            ST_DONE: begin
                acc_d       = '0;
                cnt_d       = 6'd0;
                stop_pend_d = 1'b0;
                state_d     = ST_RUN;
            end
            default: begin
                acc_d       = '0;
                cnt_d       = 6'd0;
                stop_pend_d = 1'b0;
                state_d     = ST_RUN;
            end
        endcase
    end

    // State, accumulator and fill-level registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            acc_q       <= '0;
            cnt_q       <= 6'd0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            stop_pend_q <= stop_pend_d;
        end
    end

endmodule
